// File: rtl/jtag_reg_access.sv
// ============================================================================
// Module   : jtag_reg_access
// Brief    : Debug-side GPR read/write bridge that halts the core around each
//            register-file access. Optional: JTAG_REG_AUTOINC_EN adds an
//            auto-incrementing address pointer (cmd_autoinc_i).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtag_reg_access #(
    parameter int unsigned HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
`ifdef JTAG_REG_AUTOINC_EN
    input  logic        cmd_autoinc_i,
`endif
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        halt_req_o,
    input  logic        halt_ack_i,
    output logic        jtag_we_o,
    output logic [4:0]  jtag_addr_o,
    output logic [31:0] jtag_data_o,
    input  logic [31:0] jtag_data_i
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_HALT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    // Timeout fires at the end of the HALT_TIMEOUT-th unacknowledged cycle.
    localparam logic [7:0] c_TO_LAST = 8'(HALT_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_write;
    logic [4:0]  r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_ready;
    logic        w_accept;
    logic [4:0]  w_addr_sel;

    assign w_ready  = (r_state == c_IDLE) && !rst;
    assign w_accept = cmd_valid_i && w_ready;

`ifdef JTAG_REG_AUTOINC_EN
    logic [4:0] r_ptr;

    assign w_addr_sel = cmd_autoinc_i ? r_ptr : cmd_addr_i;

    // Pointer advances on every accepted command, whatever its outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 5'd0;
        end else if (w_accept) begin
            r_ptr <= w_addr_sel + 5'd1;
        end
    end
`else
    assign w_addr_sel = cmd_addr_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
            r_write <= 1'b0;
            r_addr  <= 5'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_write <= cmd_write_i;
                        r_addr  <= w_addr_sel;
                        r_wdata <= cmd_wdata_i;
                        r_cnt   <= 8'd0;
                        r_err   <= 1'b0;
                        r_state <= c_HALT;
                    end
                end
                c_HALT: begin
                    if (halt_ack_i) begin
                        r_state <= c_ACCESS;
                    end else if (r_cnt == c_TO_LAST) begin
                        r_rdata <= 32'd0;
                        r_err   <= 1'b1;
                        r_state <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_ACCESS: begin
                    r_rdata <= r_write ? 32'd0 : jtag_data_i;
                    r_err   <= 1'b0;
                    r_state <= c_RESP;
                end
                c_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign cmd_ready_o = w_ready;
    assign halt_req_o  = (r_state != c_IDLE);
    assign rsp_valid_o = (r_state == c_RESP);
    assign rsp_rdata_o = r_rdata;
    assign rsp_err_o   = r_err;
    // x0 is hardwired; a reset arriving during ACCESS must suppress the write.
    assign jtag_we_o   = (r_state == c_ACCESS) && r_write && (r_addr != 5'd0) && !rst;
    assign jtag_addr_o = r_addr;
    assign jtag_data_o = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_jtag_reg_access.sv
// ============================================================================
// Module   : tb_jtag_reg_access
// Brief    : Directed self-checking bench for jtag_reg_access (default and
//            HALT_TIMEOUT=3 instances; autoinc steps with JTAG_REG_AUTOINC_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtag_reg_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance 1 (default timeout)
    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, halt_ack = 1'b0;
    logic [4:0]  cmd_addr = 5'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        cmd_ready, rsp_valid, rsp_err, halt_req, jtag_we;
    logic [31:0] rsp_rdata, jtag_data_out, jtag_data_in;
    logic [4:0]  jtag_addr;
`ifdef JTAG_REG_AUTOINC_EN
    logic        cmd_autoinc = 1'b0;
`endif

    // Instance 2 (HALT_TIMEOUT = 3)
    logic        t_valid = 1'b0, t_write = 1'b0, t_rsp_ready = 1'b0, t_halt_ack = 1'b0;
    logic [4:0]  t_addr = 5'd0;
    logic [31:0] t_wdata = 32'd0;
    logic        t_cmd_ready, t_rsp_valid, t_rsp_err, t_halt_req, t_jtag_we;
    logic [31:0] t_rsp_rdata, t_jtag_data_out, t_jtag_data_in;
    logic [4:0]  t_jtag_addr;
`ifdef JTAG_REG_AUTOINC_EN
    logic        t_autoinc = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int we_cnt1  = 0;
    int we_cnt2  = 0;
    logic [4:0]  we_addr = 5'd0;
    logic [31:0] we_data = 32'd0;
    int base;

    always #5 clk = ~clk;

    // Register-file model: address 5 holds 0xDEADBEEF, others a tagged pattern.
    assign jtag_data_in   = (jtag_addr == 5'd5) ? 32'hDEADBEEF : {16'hA5A5, 11'd0, jtag_addr};
    assign t_jtag_data_in = {16'hA5A5, 11'd0, t_jtag_addr};

    jtag_reg_access dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
`ifdef JTAG_REG_AUTOINC_EN
        .cmd_autoinc_i(cmd_autoinc),
`endif
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .halt_req_o(halt_req), .halt_ack_i(halt_ack),
        .jtag_we_o(jtag_we), .jtag_addr_o(jtag_addr), .jtag_data_o(jtag_data_out),
        .jtag_data_i(jtag_data_in)
    );

    jtag_reg_access #(.HALT_TIMEOUT(3)) dut_to (
        .clk(clk), .rst(rst),
        .cmd_valid_i(t_valid), .cmd_ready_o(t_cmd_ready), .cmd_write_i(t_write),
        .cmd_addr_i(t_addr), .cmd_wdata_i(t_wdata),
`ifdef JTAG_REG_AUTOINC_EN
        .cmd_autoinc_i(t_autoinc),
`endif
        .rsp_valid_o(t_rsp_valid), .rsp_ready_i(t_rsp_ready), .rsp_rdata_o(t_rsp_rdata),
        .rsp_err_o(t_rsp_err), .halt_req_o(t_halt_req), .halt_ack_i(t_halt_ack),
        .jtag_we_o(t_jtag_we), .jtag_addr_o(t_jtag_addr), .jtag_data_o(t_jtag_data_out),
        .jtag_data_i(t_jtag_data_in)
    );

    always @(posedge clk) begin
        if (jtag_we) begin
            we_cnt1 <= we_cnt1 + 1;
            we_addr <= jtag_addr;
            we_data <= jtag_data_out;
        end
        if (t_jtag_we) begin
            we_cnt2 <= we_cnt2 + 1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

`ifdef JTAG_REG_AUTOINC_EN
    task automatic do_read(input logic [4:0] a, input logic ai, output logic [31:0] rd);
        halt_ack    = 1'b1;
        cmd_valid   = 1'b1;
        cmd_write   = 1'b0;
        cmd_addr    = a;
        cmd_autoinc = ai;
        tick;
        cmd_valid   = 1'b0;
        cmd_autoinc = 1'b0;
        tick;
        tick;
        rd = rsp_rdata;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask
`endif

    initial begin
        // ---------------- reset state
        tick;
        tick;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", rsp_err, 0);
        check("rst_halt_req", halt_req, 0);
        check("rst_we", jtag_we, 0);
        check("rst_addr", jtag_addr, 0);
        check("rst_data", jtag_data_out, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1);

        // ---------------- halt_ack in IDLE has no effect
        halt_ack = 1'b1;
        tick;
        check("idle_ack_halt", halt_req, 0);
        check("idle_ack_ready", cmd_ready, 1);

        // ---------------- read addr 5, ack already high
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd5; cmd_wdata = 32'hFFFFFFFF;
        tick;                                   // HALT (N+1)
        check("rd_halt_req", halt_req, 1);
        check("rd_ready_low", cmd_ready, 0);
        check("rd_valid_n1", rsp_valid, 0);
        check("rd_addr", jtag_addr, 5);
        cmd_addr = 5'd12;                       // must be ignored outside IDLE
        tick;                                   // ACCESS (N+2)
        check("rd_addr_hold", jtag_addr, 5);
        check("rd_valid_n2", rsp_valid, 0);
        check("rd_no_we", jtag_we, 0);
        cmd_valid = 1'b0;
        tick;                                   // RESP (N+3)
        check("rd_valid_n3", rsp_valid, 1);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        check("rd_err", rsp_err, 0);
        halt_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check("hold_ready", cmd_ready, 0);
        end
        check("hold_halt", halt_req, 1);

        // ---------------- reset during ACCESS of a write (response pending first)
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rd_done_valid", rsp_valid, 0);
        check("rd_done_halt", halt_req, 0);
        check("rd_done_ready", cmd_ready, 1);
        base = we_cnt1;
        halt_ack = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd9; cmd_wdata = 32'h0BADF00D;
        tick;                                   // HALT
        cmd_valid = 1'b0;
        tick;                                   // ACCESS
        check("rstacc_we_before", jtag_we, 1);
        rst = 1'b1;
        #1;
        check("rstacc_we_gated", jtag_we, 0);
        tick;
        check("rstacc_ready", cmd_ready, 0);
        check("rstacc_valid", rsp_valid, 0);
        check("rstacc_rdata", rsp_rdata, 0);
        check("rstacc_err", rsp_err, 0);
        check("rstacc_halt", halt_req, 0);
        check("rstacc_we", jtag_we, 0);
        check("rstacc_addr", jtag_addr, 0);
        check("rstacc_data", jtag_data_out, 0);
        check("rstacc_no_pulse", 32'(we_cnt1 - base), 0);
        rst = 1'b0;
        #1;
        check("rstacc_ready_after", cmd_ready, 1);

        // ---------------- write addr 7, ack delayed 4 cycles
        halt_ack = 1'b0;
        base = we_cnt1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd7; cmd_wdata = 32'h12345678;
        tick;                                   // HALT
        cmd_valid = 1'b0;
        check("wr_addr", jtag_addr, 7);
        check("wr_data", jtag_data_out, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            check("wr_wait_we", jtag_we, 0);
            check("wr_wait_halt", halt_req, 1);
            tick;
        end
        halt_ack = 1'b1;
        tick;                                   // ACCESS
        check("wr_we", jtag_we, 1);
        tick;                                   // RESP
        check("wr_we_drop", jtag_we, 0);
        check("wr_valid", rsp_valid, 1);
        check("wr_rdata", rsp_rdata, 0);
        check("wr_err", rsp_err, 0);
        check("wr_pulses", 32'(we_cnt1 - base), 1);
        check("wr_pulse_addr", we_addr, 7);
        check("wr_pulse_data", we_data, 32'h12345678);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // ---------------- write to addr 0 must not pulse
        base = we_cnt1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd0; cmd_wdata = 32'hAAAA5555;
        tick;                                   // HALT
        cmd_valid = 1'b0;
        tick;                                   // ACCESS
        check("w0_we", jtag_we, 0);
        tick;                                   // RESP
        check("w0_valid", rsp_valid, 1);
        check("w0_err", rsp_err, 0);
        check("w0_pulses", 32'(we_cnt1 - base), 0);
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;

        // ---------------- timeout instance, HALT_TIMEOUT = 3
        t_valid = 1'b1; t_write = 1'b1; t_addr = 5'd3; t_wdata = 32'hFFFF0000;
        tick;                                   // HALT cycle 1
        t_valid = 1'b0;
        check("to_halt", t_halt_req, 1);
        check("to_valid_c1", t_rsp_valid, 0);
        tick;                                   // HALT cycle 2
        check("to_valid_c2", t_rsp_valid, 0);
        tick;                                   // HALT cycle 3
        check("to_valid_c3", t_rsp_valid, 0);
        tick;                                   // RESP
        check("to_valid", t_rsp_valid, 1);
        check("to_err", t_rsp_err, 1);
        check("to_rdata", t_rsp_rdata, 0);
        check("to_no_we", 32'(we_cnt2), 0);
        check("to_halt_resp", t_halt_req, 1);
        t_rsp_ready = 1'b1;
        tick;
        t_rsp_ready = 1'b0;
        check("to_halt_drop", t_halt_req, 0);
        check("to_valid_drop", t_rsp_valid, 0);

`ifdef JTAG_REG_AUTOINC_EN
        begin
            logic [31:0] rd;
            logic [4:0]  ea;
            do_read(5'd30, 1'b0, rd);
            check("ai_seed", rd, {16'hA5A5, 11'd0, 5'd30});
            for (int i = 0; i < 3; i++) begin
                ea = 5'd31 + 5'(i);
                do_read(5'd5, 1'b1, rd);
                check("ai_read", rd, {16'hA5A5, 11'd0, ea});
            end
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
